// File: rtl/mic_adc_reader_pkg.sv
// Shared constants and state encoding for the microphone ADC reader.
// The volume/peak logic imports MIC_SAMPLE_W from here as well.
package mic_pkg;

    localparam int MIC_FRAME_BITS = 16;
    localparam int MIC_LEAD_BITS  = 4;
    localparam int MIC_SAMPLE_W   = 12;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } mic_state_e;

endpackage

// File: rtl/mic_adc_reader_if.sv
// ADC pin side plus the sample stream handed to the volume logic.
// master = the reader, slave = the board/ADC and sample consumer side.
interface mic_adc_if;
    import mic_pkg::*;

    logic                    enable;
    logic                    miso;
    logic                    sclk;
    logic                    cs_n;
    logic [MIC_SAMPLE_W-1:0] sample;
    logic                    sample_valid;
    logic                    lead_err;

    modport master (
        input  enable, miso,
        output sclk, cs_n, sample, sample_valid, lead_err
    );

    modport slave (
        output enable, miso,
        input  sclk, cs_n, sample, sample_valid, lead_err
    );

endinterface

// File: rtl/mic_adc_reader.sv
// Serial reader for an ADCS7476-style ADC: one 16-bit frame per sample
// period, 12-bit result published with a single-cycle valid strobe.
module mic_adc_reader
    import mic_pkg::*;
#(
    parameter int CLK_DIV       = 50,
    parameter int SAMPLE_PERIOD = 5000
) (
    input  logic      clk,
    input  logic      rst_n,
    mic_adc_if.master bus
);

    // Reject parameter sets that cannot fit a whole frame in one period.
    if (CLK_DIV < 2 || CLK_DIV > 255 || SAMPLE_PERIOD < 33 * CLK_DIV + 2) begin : g_bad_params
        $error("mic_adc_reader: illegal CLK_DIV/SAMPLE_PERIOD");
    end

    localparam int PW = $clog2(SAMPLE_PERIOD);

    mic_state_e                state_q;
    logic [PW-1:0]             per_q, per_d;
    logic [7:0]                div_q;
    logic [3:0]                bit_q;
    logic [MIC_FRAME_BITS-1:0] shift_q;
    logic                      sclk_q, cs_n_q, valid_q, lead_err_q;
    logic [MIC_SAMPLE_W-1:0]   sample_q;

    // Period counter: parked at 0 while disabled so re-enable starts a frame at once.
    always_comb begin
        per_d = '0;
        if (bus.enable && per_q != PW'(SAMPLE_PERIOD - 1))
            per_d = per_q + 1'b1;
    end

    // Period counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) per_q <= '0;
        else        per_q <= per_d;
    end

    // Frame FSM: chip select, sclk divider, bit counter, capture and publish.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            div_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            sclk_q     <= 1'b1;
            cs_n_q     <= 1'b1;
            valid_q    <= 1'b0;
            lead_err_q <= 1'b0;
            sample_q   <= '0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    sclk_q <= 1'b1;
                    cs_n_q <= 1'b1;
                    if (bus.enable && per_q == '0) begin
                        state_q <= SETUP;
                        cs_n_q  <= 1'b0;
                        div_q   <= '0;
                    end
                end
                SETUP: begin
                    // sclk held high for one half-period to meet ADC setup time.
                    if (div_q == 8'(CLK_DIV - 1)) begin
                        div_q   <= '0;
                        bit_q   <= '0;
                        sclk_q  <= 1'b0;
                        state_q <= SHIFT;
                    end else begin
                        div_q <= div_q + 1'b1;
                    end
                end
                SHIFT: begin
                    if (div_q == 8'(CLK_DIV - 1)) begin
                        div_q <= '0;
                        if (!sclk_q) begin
                            // Rising sclk: miso has had a full low phase to settle.
                            sclk_q  <= 1'b1;
                            shift_q <= {shift_q[MIC_FRAME_BITS-2:0], bus.miso};
                        end else if (bit_q == 4'(MIC_FRAME_BITS - 1)) begin
                            cs_n_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            sclk_q <= 1'b0;
                            bit_q  <= bit_q + 1'b1;
                        end
                    end else begin
                        div_q <= div_q + 1'b1;
                    end
                end
                DONE: begin
                    sample_q   <= shift_q[MIC_SAMPLE_W-1:0];
                    lead_err_q <= |shift_q[MIC_FRAME_BITS-1:MIC_SAMPLE_W];
                    valid_q    <= 1'b1;
                    state_q    <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.sclk         = sclk_q;
    assign bus.cs_n         = cs_n_q;
    assign bus.sample       = sample_q;
    assign bus.sample_valid = valid_q;
    assign bus.lead_err     = lead_err_q;

endmodule

// File: tb/tb_mic_adc_reader.sv
// Directed bench for mic_adc_reader with a behavioural ADC model.
module tb_mic_adc_reader;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mic_adc_if bus ();

    mic_adc_reader #(.CLK_DIV(2), .SAMPLE_PERIOD(100)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    always @(posedge clk) cyc++;

    // ADC model: first bit valid at cs_n fall, next bit after each sclk fall
    // that follows a rising edge.
    logic [15:0] word_q[$];
    logic [15:0] cur_word = 16'h0;
    int          rises = 0;

    initial bus.miso = 1'b0;

    always @(negedge bus.cs_n) begin
        cur_word = (word_q.size() > 0) ? word_q.pop_front() : 16'h0;
        rises    = 0;
        bus.miso = cur_word[15];
    end

    always @(posedge bus.sclk) if (bus.cs_n === 1'b0) rises++;

    always @(negedge bus.sclk)
        if (bus.cs_n === 1'b0 && rises > 0 && rises < 16) bus.miso = cur_word[15 - rises];

    // Monitor: phase lengths while selected, sclk activity while deselected.
    logic prev_cs = 1'b1, prev_sclk = 1'b1;
    int run = 0, low_len = 0, last_low_len = 0, last_rises = 0;
    int phase_bad = 0, idle_toggle = 0, cs_fall_cyc = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_cs = 1'b1; prev_sclk = 1'b1; run = 0; low_len = 0;
        end else begin
            if (bus.cs_n === 1'b0) begin
                if (prev_cs) begin
                    cs_fall_cyc = cyc; low_len = 1; run = 1;
                end else begin
                    low_len++;
                    if (bus.sclk === prev_sclk) run++;
                    else begin
                        if (run != 2) phase_bad++;
                        run = 1;
                    end
                end
            end else begin
                if (!prev_cs) begin
                    if (run != 2) phase_bad++;
                    last_low_len = low_len;
                    last_rises   = rises;
                end else if (bus.sclk !== prev_sclk || bus.sclk !== 1'b1) begin
                    idle_toggle++;
                end
            end
            prev_cs   = bus.cs_n;
            prev_sclk = bus.sclk;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_valid(output int c, output bit ok);
        ok = 1'b0;
        c  = 0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            if (bus.sample_valid === 1'b1) begin
                ok = 1'b1;
                c  = cyc;
            end
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL valid_timeout: got no strobe expected one within 400 cycles");
        end
    endtask

    task automatic wait_cs_low();
        bit seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            if (bus.cs_n === 1'b0) seen = 1'b1;
        end
        if (!seen) begin
            checks++; errors++;
            $display("FAIL cs_timeout: got cs_n high expected a frame start");
        end
    endtask

    task automatic wait_rises(input int n);
        bit seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            if (rises >= n) seen = 1'b1;
        end
        if (!seen) begin
            checks++; errors++;
            $display("FAIL rise_timeout: got %0d rises expected %0d", rises, n);
        end
    endtask

    typedef struct {
        logic [15:0] word;
        logic [11:0] exp_s;
        logic        exp_lead;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int vc, prev_vc, cnt;
        bit ok;

        vecs[0] = '{16'h0ABC, 12'hABC, 1'b0};
        vecs[1] = '{16'h0FFF, 12'hFFF, 1'b0};
        vecs[2] = '{16'h0000, 12'h000, 1'b0};
        vecs[3] = '{16'h0800, 12'h800, 1'b0};
        vecs[4] = '{16'h5123, 12'h123, 1'b1};
        vecs[5] = '{16'h0123, 12'h123, 1'b0};

        bus.enable = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_sclk",  32'(bus.sclk), 32'd1);
        chk("rst_cs_n",  32'(bus.cs_n), 32'd1);
        chk("rst_sample", 32'(bus.sample), 32'd0);
        chk("rst_valid", 32'(bus.sample_valid), 32'd0);
        chk("rst_lead",  32'(bus.lead_err), 32'd0);
        rst_n = 1'b1;

        // Continuous frames over the vector table.
        foreach (vecs[i]) word_q.push_back(vecs[i].word);
        @(negedge clk);
        bus.enable = 1'b1;
        prev_vc = 0;
        for (int i = 0; i < 6; i++) begin
            wait_valid(vc, ok);
            if (ok) begin
                chk($sformatf("sample_%0d", i), 32'(bus.sample), 32'(vecs[i].exp_s));
                chk($sformatf("lead_%0d", i), 32'(bus.lead_err), 32'(vecs[i].exp_lead));
                chk($sformatf("cs_low_len_%0d", i), 32'(last_low_len), 32'd66);
                chk($sformatf("sclk_rises_%0d", i), 32'(last_rises), 32'd16);
                if (i == 0) chk("cs_to_valid", 32'(vc - cs_fall_cyc), 32'd67);
                else        chk($sformatf("strobe_gap_%0d", i), 32'(vc - prev_vc), 32'd100);
                prev_vc = vc;
                @(negedge clk);
                chk($sformatf("valid_one_cycle_%0d", i), 32'(bus.sample_valid), 32'd0);
            end
        end

        // Reset in the middle of a frame, then a clean frame.
        word_q.push_back(16'h0456);
        word_q.push_back(16'h0321);
        wait_cs_low();
        wait_rises(7);
        rst_n = 1'b0;
        #1;
        chk("abort_sclk",   32'(bus.sclk), 32'd1);
        chk("abort_cs_n",   32'(bus.cs_n), 32'd1);
        chk("abort_sample", 32'(bus.sample), 32'd0);
        chk("abort_valid",  32'(bus.sample_valid), 32'd0);
        repeat (2) @(negedge clk);
        chk("abort_hold_valid", 32'(bus.sample_valid), 32'd0);
        rst_n = 1'b1;
        wait_valid(vc, ok);
        if (ok) begin
            chk("post_reset_sample", 32'(bus.sample), 32'h321);
            chk("post_reset_lead",   32'(bus.lead_err), 32'd0);
        end

        // Drop enable mid-shift: frame still completes, then nothing starts.
        word_q.push_back(16'h0A5A);
        word_q.push_back(16'h0777);
        wait_cs_low();
        wait_rises(4);
        bus.enable = 1'b0;
        wait_valid(vc, ok);
        if (ok) chk("drop_en_sample", 32'(bus.sample), 32'hA5A);
        cnt = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (bus.cs_n !== 1'b1) cnt++;
        end
        chk("idle_cs_low_cycles", 32'(cnt), 32'd0);
        bus.enable = 1'b1;
        @(negedge clk);
        chk("reenable_cs_n", 32'(bus.cs_n), 32'd0);
        wait_valid(vc, ok);
        if (ok) chk("reenable_sample", 32'(bus.sample), 32'h777);

        // Whole-run sclk shape.
        chk("sclk_phase_bad", 32'(phase_bad), 32'd0);
        chk("sclk_idle_toggle", 32'(idle_toggle), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before 200000");
        $fatal(1, "watchdog");
    end

endmodule
